// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and types for the 16-bit ripple-carry adder slice.
//   ADDER_WIDTH : operand/sum width (fixed at 16)
//   word_t      : one operand or sum word
//   result_t    : carry-out and sum, packed so that {carry, sum} == X + Y
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH = 16;

    typedef logic [ADDER_WIDTH-1:0] word_t;

    typedef struct packed {
        logic  carry;
        word_t sum;
    } result_t;

endpackage : adder_pkg

// File: rtl/full_adder_1bit.sv
// ----------------------------------------------------------------------------
// full_adder_1bit
//   One-bit full adder, the leaf cell of the ripple-carry chain.
//   Purely combinational.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry from the next-lower bit
//   s     out  sum bit
//   cout  out  carry into the next-higher bit
// ----------------------------------------------------------------------------
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by the sum and the carry expressions.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_1bit

// File: rtl/adder_16_bit.sv
// ----------------------------------------------------------------------------
// adder_16_bit
//   Unsigned 16-bit adder with a registered result: {Carry, Z} = X + Y,
//   one cycle after X/Y are sampled. The add path is a ripple chain of
//   full_adder_1bit cells with no carry-in; the inputs are not registered,
//   so the X/Y -> chain -> output flop path has to close in one clk period.
// Ports:
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous active-high reset, clears Z and Carry
//   X      in   16  operand A, unsigned
//   Y      in   16  operand B, unsigned
//   Z      out  16  registered sum, (X + Y) mod 2^16
//   Carry  out  1   registered carry-out, bit 16 of X + Y
// ----------------------------------------------------------------------------
module adder_16_bit
    import adder_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t X,
    input  word_t Y,
    output word_t Z,
    output logic  Carry
);

    localparam int WIDTH = ADDER_WIDTH;

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             carry_next;
    result_t          result_q;

    // There is no carry-in, so the bottom of the chain is tied low.
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1bit u_fa (
            .a    (X[i]),
            .b    (Y[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end : g_chain

    assign carry_next = carry[WIDTH];

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values that existed before the edge; blocking assignments
    // here would make the result depend on statement order.
    // NOTE: reset is synchronous, so rst only acts at a rising edge and a
    // pending sum is simply replaced by zero on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= '{carry: carry_next, sum: sum};
        end
    end

    assign Z     = result_q.sum;
    assign Carry = result_q.carry;

endmodule : adder_16_bit

// File: tb/tb_adder_16_bit.sv
// ----------------------------------------------------------------------------
// tb_adder_16_bit
//   Directed and random checks for adder_16_bit. Inputs are driven 1 ns after
//   a rising edge and the registered result is sampled 1 ns after the next
//   rising edge, so each apply() call covers exactly one add.
// ----------------------------------------------------------------------------
module tb_adder_16_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] Z;
    logic        Carry;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_16_bit dut (
        .clk   (clk),
        .rst   (rst),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .Carry (Carry)
    );

    // Drive one set of inputs, let one rising edge capture them, and settle
    // just past that edge so the registered outputs can be sampled.
    task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic r);
        rst = r;
        X   = x;
        Y   = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(16'hFFFF, 16'hFFFF, 1'b1);
        checks++;
        if (Z !== 16'h0000) begin
            failures++;
            $display("FAIL reset_z: got %h expected 0000", Z);
        end
        checks++;
        if (Carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_carry: got %b expected 0", Carry);
        end
        // A second reset edge must keep the outputs cleared.
        apply(16'h8000, 16'h8000, 1'b1);
        checks++;
        if ({Carry, Z} !== 17'h0_0000) begin
            failures++;
            $display("FAIL reset_hold: got %b_%h expected 0_0000", Carry, Z);
        end
    endtask

    task automatic test_alternating();
        apply(16'h2AAB, 16'hD554, 1'b0);
        checks++;
        if (Z !== 16'hFFFF) begin
            failures++;
            $display("FAIL alt_z: got %h expected ffff", Z);
        end
        checks++;
        if (Carry !== 1'b0) begin
            failures++;
            $display("FAIL alt_carry: got %b expected 0", Carry);
        end
    endtask

    task automatic test_wrap();
        apply(16'hFFFF, 16'h0001, 1'b0);
        checks++;
        if (Z !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_z: got %h expected 0000", Z);
        end
        checks++;
        if (Carry !== 1'b1) begin
            failures++;
            $display("FAIL wrap_carry: got %b expected 1", Carry);
        end
        apply(16'hFFFF, 16'hFFFF, 1'b0);
        checks++;
        if (Z !== 16'hFFFE) begin
            failures++;
            $display("FAIL max_z: got %h expected fffe", Z);
        end
        checks++;
        if (Carry !== 1'b1) begin
            failures++;
            $display("FAIL max_carry: got %b expected 1", Carry);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs   [4] = '{16'h0001, 16'h8000, 16'h1234, 16'h00FF};
        logic [15:0] ys   [4] = '{16'h0001, 16'h8000, 16'h4321, 16'h0001};
        logic [16:0] exps [4] = '{17'h0_0002, 17'h1_0000, 17'h0_5555, 17'h0_0100};
        for (int i = 0; i < 4; i++) begin
            apply(xs[i], ys[i], 1'b0);
            checks++;
            if ({Carry, Z} !== exps[i]) begin
                failures++;
                $display("FAIL b2b_%0d: got %b_%h expected %b_%h",
                         i, Carry, Z, exps[i][16], exps[i][15:0]);
            end
        end
        // Outputs must hold between edges even after the inputs change.
        X = 16'hAAAA;
        Y = 16'h5555;
        #3;
        checks++;
        if ({Carry, Z} !== 17'h0_0100) begin
            failures++;
            $display("FAIL hold_between_edges: got %b_%h expected 0_0100", Carry, Z);
        end
    endtask

    // X = 0, Y = i over the whole range; one reset edge is inserted midway.
    task automatic test_sweep();
        logic [16:0] expected;
        int          sweep_fail;
        sweep_fail = 0;
        for (int i = 0; i < 65536; i++) begin
            if (i == 30000) begin
                apply(16'h0000, 16'(i), 1'b1);
                expected = 17'h0_0000;
            end else begin
                apply(16'h0000, 16'(i), 1'b0);
                expected = {1'b0, 16'h0000} + {1'b0, 16'(i)};
            end
            checks++;
            if ({Carry, Z} !== expected) begin
                failures++;
                sweep_fail++;
                if (sweep_fail <= 10)
                    $display("FAIL sweep_%0d: got %b_%h expected %b_%h",
                             i, Carry, Z, expected[16], expected[15:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] expected;
        int          rand_fail;
        rand_fail = 0;
        for (int i = 0; i < 10000; i++) begin
            x        = 16'($urandom);
            y        = 16'($urandom);
            expected = {1'b0, x} + {1'b0, y};
            apply(x, y, 1'b0);
            checks++;
            if ({Carry, Z} !== expected) begin
                failures++;
                rand_fail++;
                if (rand_fail <= 10)
                    $display("FAIL random_%0d: x=%h y=%h got %b_%h expected %b_%h",
                             i, x, y, Carry, Z, expected[16], expected[15:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        X   = 16'h0000;
        Y   = 16'h0000;
        #1;
        test_reset();
        test_alternating();
        test_wrap();
        test_back_to_back();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_16_bit
